// File: rtl/mutex_master_pkg.sv
// Shared types and constants for the hardware-mutex Avalon master.
package mutex_master_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ACQ  = 3'd1,
        ST_RD_CHK  = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_HELD    = 3'd4,
        ST_WR_REL  = 3'd5
    } state_t;

    // Mutex word layout: owner tag in the upper half, lock value in the lower half
    localparam int OWNER_MSB = 31;
    localparam int OWNER_LSB = 16;
    localparam int VALUE_MSB = 15;
    localparam int VALUE_LSB = 0;

    // Slave register map (1-bit address)
    localparam logic ADDR_MUTEX = 1'b0;
    localparam logic ADDR_RESET = 1'b1;

    // Build a mutex word from an owner tag and a value
    function automatic logic [31:0] mutex_word(input logic [15:0] owner, input logic [15:0] value);
        logic [31:0] w;
        w = '0;
        w[OWNER_MSB:OWNER_LSB] = owner;
        w[VALUE_MSB:VALUE_LSB] = value;
        return w;
    endfunction

endpackage

// File: rtl/mutex_backoff_timer.sv
// 16-bit load/down-counter that times the idle gap before an acquire retry.
// load takes priority; start enables counting down; expired is high at zero.
module mutex_backoff_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        start,
    input  logic [15:0] load_value,
    output logic        expired
);

    logic [15:0] count;

    // Load on request, otherwise count down to zero and hold there
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_value;
        end else if (start && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign expired = (count == 16'd0);

endmodule

// File: rtl/mutex_lock_master.sv
// Avalon-MM master that takes and frees a hardware mutex for one requester:
// write-then-verify acquire, timed back-off on contention, release write.
// All outputs are registered from the next-state decode.
module mutex_lock_master
    import mutex_master_pkg::*;
#(
    parameter logic [15:0] OWNER_ID       = 16'h0001,
    parameter logic [15:0] LOCK_VALUE     = 16'h0001,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        acquire,
    // 'release' is a reserved word in SystemVerilog, hence release_req
    input  logic        release_req,
    output logic        busy,
    output logic        locked,
    output logic        done,
    output logic        fail,
    output logic [15:0] retries,
    output logic        avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [31:0] ACQ_WORD     = mutex_word(OWNER_ID, LOCK_VALUE);
    localparam logic [31:0] REL_WORD     = mutex_word(OWNER_ID, 16'h0000);
    // Timer reaches zero after BACKOFF_CYCLES idle cycles when loaded with N-1
    localparam logic [15:0] BACKOFF_LOAD = 16'(BACKOFF_CYCLES - 1);
    localparam logic [15:0] RETRY_LIMIT  = 16'(MAX_RETRIES);

    state_t      state, state_nxt;
    logic        busy_nxt, locked_nxt, done_nxt, fail_nxt;
    logic        read_nxt, write_nxt;
    logic [31:0] wdata_nxt;
    logic [15:0] retries_nxt, retry_inc;
    logic        tmr_load, tmr_expired;

    mutex_backoff_timer u_backoff (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .start      (state == ST_BACKOFF),
        .load_value (BACKOFF_LOAD),
        .expired    (tmr_expired)
    );

    // Saturating failed-verify count
    assign retry_inc = (retries == 16'hFFFF) ? retries : retries + 16'd1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus next values of every registered output
    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        fail_nxt    = 1'b0;
        retries_nxt = retries;
        tmr_load    = 1'b0;

        case (state)
            ST_IDLE: begin
                // release while idle is dropped; acquire wins a tie
                if (acquire) begin
                    state_nxt   = ST_WR_ACQ;
                    retries_nxt = 16'd0;
                end
            end
            ST_WR_ACQ: begin
                if (!avm_waitrequest) state_nxt = ST_RD_CHK;
            end
            ST_RD_CHK: begin
                if (!avm_waitrequest) begin
                    if (avm_readdata == ACQ_WORD) begin
                        state_nxt = ST_HELD;
                        done_nxt  = 1'b1;
                    end else begin
                        retries_nxt = retry_inc;
                        if ((RETRY_LIMIT != 16'd0) && (retry_inc == RETRY_LIMIT)) begin
                            state_nxt = ST_IDLE;
                            fail_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_BACKOFF;
                            tmr_load  = 1'b1;
                        end
                    end
                end
            end
            ST_BACKOFF: begin
                if (tmr_expired) state_nxt = ST_WR_ACQ;
            end
            ST_HELD: begin
                // release wins a tie; a repeated acquire just acknowledges
                if (release_req) begin
                    state_nxt = ST_WR_REL;
                end else if (acquire) begin
                    done_nxt = 1'b1;
                end
            end
            ST_WR_REL: begin
                if (!avm_waitrequest) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Bus and status levels follow the state being entered
        write_nxt  = (state_nxt == ST_WR_ACQ) || (state_nxt == ST_WR_REL);
        read_nxt   = (state_nxt == ST_RD_CHK);
        busy_nxt   = (state_nxt != ST_IDLE) && (state_nxt != ST_HELD);
        locked_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_WR_REL);
        wdata_nxt  = 32'd0;
        if (state_nxt == ST_WR_ACQ) wdata_nxt = ACQ_WORD;
        if (state_nxt == ST_WR_REL) wdata_nxt = REL_WORD;
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy          <= 1'b0;
            locked        <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            retries       <= 16'd0;
            avm_address   <= ADDR_MUTEX;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= 32'd0;
        end else begin
            busy          <= busy_nxt;
            locked        <= locked_nxt;
            done          <= done_nxt;
            fail          <= fail_nxt;
            retries       <= retries_nxt;
            avm_address   <= ADDR_MUTEX;
            avm_read      <= read_nxt;
            avm_write     <= write_nxt;
            avm_writedata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mutex_lock_master.sv
// Bench for mutex_lock_master: a behavioural mutex slave with a scripted
// competing owner, random wait states, and latency/count expectations
// derived from the acquire/retry/release timing rules.
module tb_mutex_lock_master;

    localparam int B    = 16;
    localparam int B2   = 3;
    localparam int LIM  = 3000;
    localparam logic [31:0] ACQ = 32'h0001_0001;
    localparam logic [31:0] REL = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, acquire, release_req;
    logic        busy, locked, done, fail;
    logic [15:0] retries;
    logic        avm_address, avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest;

    // second master, MAX_RETRIES=2, facing a mutex permanently held by owner 2
    logic        acquire2, release2, wait2;
    logic        busy2, locked2, done2, fail2;
    logic [15:0] retries2;
    logic        addr2, rd2, wr2;
    logic [31:0] wd2, rdata2;

    mutex_lock_master #(.OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
                        .BACKOFF_CYCLES(B), .MAX_RETRIES(0)) dut (
        .clk(clk), .reset_n(reset_n), .acquire(acquire), .release_req(release_req),
        .busy(busy), .locked(locked), .done(done), .fail(fail), .retries(retries),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    mutex_lock_master #(.OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
                        .BACKOFF_CYCLES(B2), .MAX_RETRIES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .acquire(acquire2), .release_req(release2),
        .busy(busy2), .locked(locked2), .done(done2), .fail(fail2), .retries(retries2),
        .avm_address(addr2), .avm_read(rd2), .avm_write(wr2),
        .avm_writedata(wd2), .avm_readdata(rdata2),
        .avm_waitrequest(wait2)
    );

    // ---------------- mutex slave model ----------------
    logic [31:0] mtx = 32'd0;        // word as stored by our master
    logic [31:0] last_wd = 32'd0, last_rd = 32'd0;
    int fail_rd = 0, n_wr = 0, n_rd = 0, n_stall = 0, n_quiet = 0;
    int base_fail = 0, hold_k = 0;   // other owner holds for hold_k failed verifies
    logic other_held;
    logic force_wait = 1'b0, rnd_wait = 1'b0;
    int   wait_pct = 0;

    assign other_held      = (fail_rd - base_fail) < hold_k;
    assign avm_readdata    = other_held ? 32'h0002_0001 : mtx;
    assign avm_waitrequest = force_wait | rnd_wait;

    always @(negedge clk) rnd_wait <= ($urandom_range(0, 99) < wait_pct);

    always @(posedge clk) begin
        if (reset_n) begin
            if ((avm_read || avm_write) && avm_waitrequest) n_stall <= n_stall + 1;
            if (busy && !avm_read && !avm_write) n_quiet <= n_quiet + 1;
            if (avm_write && !avm_waitrequest) begin
                n_wr    <= n_wr + 1;
                last_wd <= avm_writedata;
                if (!other_held && (mtx[15:0] == 16'd0 || mtx[31:16] == avm_writedata[31:16]))
                    mtx <= avm_writedata;
            end
            if (avm_read && !avm_waitrequest) begin
                n_rd    <= n_rd + 1;
                last_rd <= avm_readdata;
                if (other_held) fail_rd <= fail_rd + 1;
            end
        end
    end

    // ---------------- bus protocol watcher ----------------
    logic        prev_hold;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_wd;
    int          proto_err = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_hold <= 1'b0;
        end else begin
            if ((avm_read && avm_write) || (rd2 && wr2) || avm_address || addr2)
                proto_err <= proto_err + 1;
            else if (prev_hold && (avm_read != prev_rd || avm_write != prev_wr ||
                                   avm_writedata != prev_wd))
                proto_err <= proto_err + 1;
            prev_hold <= (avm_read || avm_write) && avm_waitrequest;
            prev_rd   <= avm_read;
            prev_wr   <= avm_write;
            prev_wd   <= avm_writedata;
        end
    end

    // ---------------- checking helpers ----------------
    int n_pass = 0, n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic pulse(input logic a, input logic r);
        acquire     = a;
        release_req = r;
        @(negedge clk);
        acquire     = 1'b0;
        release_req = 1'b0;
    endtask

    // Acquire against a mutex the other owner holds for k failed verifies.
    // A stray release is fired while busy; it must be dropped.
    task automatic run_acquire(input int k, input string tag);
        int w0, r0, s0, q0, lat;
        w0 = n_wr; r0 = n_rd; s0 = n_stall; q0 = n_quiet;
        base_fail = fail_rd;
        hold_k    = k;
        pulse(1'b1, 1'b0);
        lat = 1;
        while (!done && lat < LIM) begin
            release_req = (lat == 2);
            @(negedge clk);
            lat++;
        end
        release_req = 1'b0;
        chk({tag, "_done"},    done, 1);
        chk({tag, "_lat"},     lat, 3 + (n_stall - s0) + k * (B + 2));
        chk({tag, "_retries"}, retries, k);
        chk({tag, "_locked"},  locked, 1);
        chk({tag, "_quiet"},   n_quiet - q0, k * B);
        chk({tag, "_writes"},  n_wr - w0, k + 1);
        chk({tag, "_reads"},   n_rd - r0, k + 1);
        chk({tag, "_rdval"},   last_rd, ACQ);
        @(negedge clk);
        chk({tag, "_done1"},   done, 0);
        chk({tag, "_held"},    locked, 1);
    endtask

    task automatic run_release(input string tag);
        int s0, lat;
        s0 = n_stall;
        pulse(1'b0, 1'b1);
        lat = 1;
        while (!done && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done"},   done, 1);
        chk({tag, "_lat"},    lat, 2 + (n_stall - s0));
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_wd"},     last_wd, REL);
        chk({tag, "_free"},   mtx[15:0], 0);
        @(negedge clk);
        chk({tag, "_done1"},  done, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int w0, lat;
        reset_n = 1'b0; acquire = 1'b0; release_req = 1'b0;
        acquire2 = 1'b0; release2 = 1'b0; wait2 = 1'b0; rdata2 = 32'h0002_0001;
        repeat (2) @(negedge clk);
        chk("rst_flags",   {busy, locked, done, fail, avm_read, avm_write, avm_address}, 0);
        chk("rst_retries", retries, 0);
        chk("rst_wd",      avm_writedata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // free mutex, zero wait states: write N+1, read N+2, done N+3
        w0 = n_wr;
        pulse(1'b1, 1'b0);
        chk("t1_wr",  {avm_write, avm_read}, 2'b10);
        chk("t1_wd",  avm_writedata, ACQ);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_rd",  {avm_write, avm_read}, 2'b01);
        @(negedge clk);
        chk("t1_done", {done, locked}, 2'b11);
        chk("t1_retries", retries, 0);
        chk("t1_rdval", last_rd, ACQ);
        @(negedge clk);
        chk("t1_pulse", {done, locked}, 2'b01);
        chk("t1_writes", n_wr - w0, 1);

        // acquire while held: done next cycle, no bus traffic
        w0 = n_wr;
        pulse(1'b1, 1'b0);
        chk("hacq_done", {done, locked, busy, avm_write, avm_read}, 5'b11000);
        @(negedge clk);
        chk("hacq_pulse", done, 0);
        chk("hacq_nowr",  n_wr - w0, 0);

        // release with 4 stalled cycles: data held stable, done after accept
        force_wait = 1'b1;
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("rel_wr", {avm_write, done, locked}, 3'b101);
            chk("rel_wd", avm_writedata, REL);
            if (i < 3) @(negedge clk);
        end
        force_wait = 1'b0;
        @(negedge clk);
        chk("rel_done", {done, locked, avm_write, busy}, 4'b1000);
        @(negedge clk);
        chk("rel_pulse", done, 0);
        chk("rel_mtx",   mtx, REL);

        // release while idle: ignored
        w0 = n_wr;
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("irel_quiet", {done, avm_write, busy, locked}, 0);
            @(negedge clk);
        end
        chk("irel_nowr", n_wr - w0, 0);

        // simultaneous commands: acquire wins in IDLE, release wins in HELD
        pulse(1'b1, 1'b1);
        chk("sim_idle_wd", {avm_write, avm_writedata}, {1'b1, ACQ});
        repeat (2) @(negedge clk);
        chk("sim_idle_done", {done, locked}, 2'b11);
        @(negedge clk);
        pulse(1'b1, 1'b1);
        chk("sim_held_wd", {avm_write, avm_writedata}, {1'b1, REL});
        @(negedge clk);
        chk("sim_held_done", {done, locked}, 2'b10);
        @(negedge clk);

        // contention: other owner frees after the 3rd failed verify
        run_acquire(3, "cont3");
        run_release("cont3_rel");

        // randomized wait states and contention depth
        for (int t = 0; t < 6; t++) begin
            wait_pct = $urandom_range(0, 50);
            run_acquire($urandom_range(0, 3), "rnd_acq");
            run_release("rnd_rel");
        end
        wait_pct = 0;
        @(negedge clk);

        // MAX_RETRIES=2 against a permanently held mutex: fail after 2nd verify
        acquire2 = 1'b1;
        @(negedge clk);
        acquire2 = 1'b0;
        lat = 1;
        while (!fail2 && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        chk("mr_fail",    fail2, 1);
        chk("mr_lat",     lat, 3 + (B2 + 2));
        chk("mr_retries", retries2, 2);
        chk("mr_state",   {locked2, busy2, done2, rd2, wr2}, 0);
        @(negedge clk);
        chk("mr_pulse",   fail2, 0);

        // reset while RD_CHK is stalled
        pulse(1'b1, 1'b0);
        @(negedge clk);
        force_wait = 1'b1;
        @(negedge clk);
        chk("rrst_pre", avm_read, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rrst_flags",   {busy, locked, done, fail, avm_read, avm_write, avm_address}, 0);
        chk("rrst_retries", retries, 0);
        chk("rrst_wd",      avm_writedata, 0);
        force_wait = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_acquire(0, "post_rst");
        run_release("post_rst_rel");

        chk("protocol", proto_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
